// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that lets NREQ requesters share the write port of a
//   FIFO. A grant lasts up to BURST beats. It ends early if the owner drops
//   valid. Exactly one IDLE cycle separates consecutive grants.
//
// Handshake: requester i offers a word by raising req_valid[i]. It holds
//   req_valid[i] and its slice of req_data until req_ready[i] is high. A
//   word is transferred on a rising wclk edge where
//   req_valid[i] & req_ready[i]. req_ready[i] is high only for the owner,
//   and only while the FIFO is not full (req_ready[owner] == wen).
//
// Optional feature: define FIFO_ARB_STATS_EN to build per-requester 16-bit
//   saturating accepted-beat counters on beat_count. Without it beat_count
//   is tied to 0.
//
// Ports:
//   wclk        in   write-side clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   [NREQ]        requester i offers a word
//   req_data    in   [NREQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   req_ready   out  [NREQ]        requester i word accepted this cycle
//   full        in   FIFO full flag
//   wen         out  FIFO write enable
//   data_in     out  [WIDTH]       FIFO write data (0 when idle)
//   grant_id    out  [3]           current owner, 0 when idle
//   busy        out  high while in GRANT (exposes FSM state)
//   beat_count  out  [NREQ*16]     per-requester accepted-beat counters
module fifo_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  full,
  output logic                  wen,
  output logic [WIDTH-1:0]      data_in,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic [NREQ*16-1:0]    beat_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_owner, w_owner_nxt;
  logic [2:0] r_last_owner, w_last_owner_nxt;
  logic [7:0] r_beats, w_beats_nxt;

  logic       w_any;
  logic [2:0] w_pick;
  logic       w_owner_valid;

  // Round-robin pick. Scan distances from far to near so that the nearest
  // valid requester after last_owner is the one written last and wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req_valid[j] && (j == ((int'(r_last_owner) + k) % NREQ))) begin
          w_any  = 1'b1;
          w_pick = 3'(j);
        end
      end
    end
  end

  // Owner-indexed muxes. They are written as decoded loops so the
  // index width always matches the vectors.
  always_comb begin
    w_owner_valid = 1'b0;
    data_in       = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (r_owner == 3'(j)) begin
        w_owner_valid = req_valid[j];
        if (r_state == ST_GRANT) data_in = req_data[j*WIDTH +: WIDTH];
      end
    end
  end

  assign busy     = (r_state == ST_GRANT);
  assign wen      = busy & w_owner_valid & ~full;
  assign grant_id = busy ? r_owner : 3'd0;

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = wen && (r_owner == 3'(j));
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_beats_nxt      = r_beats;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_pick;
          w_beats_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!w_owner_valid) begin
          // The owner withdrew. Its turn still counts as used, so the next
          // pick starts after it and no requester can starve.
          w_state_nxt      = ST_IDLE;
          w_last_owner_nxt = r_owner;
        end else if (wen) begin
          w_beats_nxt = r_beats + 8'd1;
          if (r_beats == 8'(BURST - 1)) begin
            w_state_nxt      = ST_IDLE;
            w_last_owner_nxt = r_owner;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // last_owner resets to NREQ-1, so requester 0 is first after reset.
  always_ff @(posedge wclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= 3'(NREQ - 1);
      r_beats      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_beats      <= w_beats_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_beat_cnt [NREQ];

  always_ff @(posedge wclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NREQ; j++) r_beat_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        if (req_ready[j] && (r_beat_cnt[j] != 16'hFFFF)) begin
          r_beat_cnt[j] <= r_beat_cnt[j] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    beat_count = '0;
    for (int j = 0; j < NREQ; j++) beat_count[j*16 +: 16] = r_beat_cnt[j];
  end
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (WIDTH=8, NREQ=4, BURST=4).
// Requester i always offers the word i*64 + (number of words it has
// already had accepted). Every expected value below is hand-derived from
// that rule.
module tb_fifo_write_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic                  wclk;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  full;
  logic                  wen;
  logic [WIDTH-1:0]      data_in;
  logic [2:0]            grant_id;
  logic                  busy;
  logic [NREQ*16-1:0]    beat_count;

  fifo_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk       (wclk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .wen        (wen),
    .data_in    (data_in),
    .grant_id   (grant_id),
    .busy       (busy),
    .beat_count (beat_count)
  );

  // clock / reset block
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cnt [NREQ];
  int n_writes = 0;

  logic                  s_wen, s_busy;
  logic [NREQ-1:0]       s_ready;
  logic [WIDTH-1:0]      s_data;
  logic [2:0]            s_gid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 8'((i * 64 + cnt[i]) & 255);
  endtask

  // One clock. The outputs are sampled mid-low-phase, with the inputs
  // already set for this cycle. Then the edge is taken and the data of
  // accepted requesters is advanced. The task returns on the next negedge.
  task automatic cyc();
    #1;
    s_wen   = wen;
    s_ready = req_ready;
    s_data  = data_in;
    s_gid   = grant_id;
    s_busy  = busy;
    if (wen) n_writes++;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (s_ready[i]) cnt[i]++;
    drive_data();
    @(negedge wclk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(s_busy), 64'd0);
    check({tag, "_wen"},  64'(s_wen),  64'd0);
    check({tag, "_gid"},  64'(s_gid),  64'd0);
    check({tag, "_rdy"},  64'(s_ready), 64'd0);
    check({tag, "_data"}, 64'(s_data), 64'd0);
  endtask

  task automatic check_beat(input string tag, input int owner, input int data);
    check({tag, "_busy"}, 64'(s_busy), 64'd1);
    check({tag, "_wen"},  64'(s_wen),  64'd1);
    check({tag, "_gid"},  64'(s_gid),  64'(owner));
    check({tag, "_rdy"},  64'(s_ready), 64'(1 << owner));
    check({tag, "_data"}, 64'(s_data), 64'(data));
  endtask

  initial begin
    int w0;
    int got3;
    bit done;
    logic [63:0] exp_bc;

    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    full      = 1'b0;
    drive_data();
    @(negedge wclk);
    cyc();
    cyc();
    check_idle("reset");
    check("reset_bc", beat_count, 64'd0);

    // All four requesters continuously valid: grants 0,1,2,3,0, each 4
    // beats, with one idle cycle before each grant.
    reset_n   = 1'b1;
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      cyc();
      check_idle($sformatf("rr_gap%0d", g));
      for (int b = 0; b < BURST; b++) begin
        cyc();
        check_beat($sformatf("rr_g%0d_b%0d", g, b), g % 4, (g % 4) * 64 + (g / 4) * 4 + b);
      end
    end
    req_valid = '0;
    cyc();
    check("rr_end_busy", 64'(s_busy), 64'd0);

    // Only requester 2, three words, then it drops valid mid-grant.
    w0 = n_writes;
    req_valid = 4'b0100;
    cyc();
    check_idle("r2_sel");
    for (int b = 0; b < 3; b++) begin
      cyc();
      check_beat($sformatf("r2_b%0d", b), 2, 128 + 4 + b);
    end
    req_valid = '0;
    cyc();
    check("r2_drop_busy", 64'(s_busy), 64'd1);
    check("r2_drop_wen",  64'(s_wen),  64'd0);
    check("r2_drop_rdy",  64'(s_ready), 64'd0);
    check("r2_drop_gid",  64'(s_gid),  64'd2);
    cyc();
    check_idle("r2_idle");
    check("r2_writes", 64'(n_writes - w0), 64'd3);

    // Requester 1 with the FIFO full for 5 cycles after beat 2.
    req_valid = 4'b0010;
    cyc();
    check_idle("full_sel");
    for (int b = 0; b < 2; b++) begin
      cyc();
      check_beat($sformatf("full_pre_b%0d", b), 1, 64 + 4 + b);
    end
    full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      check($sformatf("full_hold%0d_wen", c),  64'(s_wen),  64'd0);
      check($sformatf("full_hold%0d_rdy", c),  64'(s_ready), 64'd0);
      check($sformatf("full_hold%0d_busy", c), 64'(s_busy), 64'd1);
      check($sformatf("full_hold%0d_gid", c),  64'(s_gid),  64'd1);
    end
    full = 1'b0;
    for (int b = 2; b < 4; b++) begin
      cyc();
      check_beat($sformatf("full_post_b%0d", b), 1, 64 + 4 + b);
    end
    req_valid = '0;
    cyc();
    check_idle("full_done");

    // All valid again: last owner was 1, so 2 is granted. Reset after
    // beat 2 must kill the write at once, and requester 0 wins afterwards.
    req_valid = 4'hF;
    cyc();
    check_idle("rst_sel");
    for (int b = 0; b < 2; b++) begin
      cyc();
      check_beat($sformatf("rst_b%0d", b), 2, 128 + 7 + b);
    end
    reset_n = 1'b0;
    #1;
    check("rst_now_wen",  64'(wen),       64'd0);
    check("rst_now_busy", 64'(busy),      64'd0);
    check("rst_now_gid",  64'(grant_id),  64'd0);
    check("rst_now_rdy",  64'(req_ready), 64'd0);
    check("rst_now_data", 64'(data_in),   64'd0);
    cyc();
    check_idle("rst_held");
    reset_n = 1'b1;
    cyc();
    check_idle("rst_rel_sel");
    cyc();
    check_beat("rst_rel_first", 0, 8);
    req_valid = '0;

    // Stats: 100 beats from requester 3 after a fresh reset.
    reset_n = 1'b0;
    cyc();
    cyc();
    check("stats_reset_bc", beat_count, 64'd0);
    reset_n   = 1'b1;
    req_valid = 4'b1000;
    got3 = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      cyc();
      if (s_ready[3]) got3++;
      if (s_ready[2:0] != 3'b000) check("stats_other_rdy", 64'(s_ready), 64'h8);
      if (got3 == 100) begin
        req_valid = '0;
        done = 1'b1;
      end
    end
    check("stats_done_in_budget", 64'(done), 64'd1);
    check("stats_beats3", 64'(got3), 64'd100);
    cyc();
`ifdef FIFO_ARB_STATS_EN
    exp_bc = 64'd100 << 48;
`else
    exp_bc = 64'd0;
`endif
    check("stats_bc", beat_count, exp_bc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data word width, matching the FIFO data_in width.
REQ-002 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter BURST, default 4: maximum beats per grant, range 1..255.
REQ-004 wclk  in  1: single clock, rising-edge, shared with the FIFO write side.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ: bit i set means requester i offers a word.
REQ-007 req_data  in  NREQ*WIDTH: requester i word at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  out  NREQ: bit i means requester i's word is accepted this cycle.
REQ-009 full  in  1: FIFO full flag, write domain.
REQ-010 wen  out  1: FIFO write enable.
REQ-011 data_in  out  WIDTH: FIFO write data.
REQ-012 grant_id  out  3: index of the current owner; 0 when idle.
REQ-013 busy  out  1: high in GRANT state.
REQ-014 beat_count  out  NREQ*16: per-requester accepted-beat counters (see Configuration).

Function
REQ-015 The FSM SHALL have two states, IDLE and GRANT, with registered owner, beat counter and last_owner.
REQ-016 In IDLE with any req_valid set, the block SHALL select the first set requester in circular order starting at last_owner+1 mod NREQ, latch it as owner, clear beats and enter GRANT next cycle.
REQ-017 In IDLE with no req_valid set, the block SHALL stay in IDLE.
REQ-018 In GRANT, wen SHALL equal req_valid[owner] & ~full, combinationally.
REQ-019 In GRANT, req_ready[owner] SHALL equal wen; all other req_ready bits and all bits in IDLE SHALL be 0.
REQ-020 data_in SHALL equal req_data of owner in GRANT and 0 in IDLE.
REQ-021 A beat SHALL be counted only on a cycle with wen high.
REQ-022 While full is high, the grant SHALL be held with no beat counted, with no timeout.
REQ-023 GRANT SHALL return to IDLE and set last_owner=owner after the cycle whose beat makes beats==BURST.
REQ-024 GRANT SHALL return to IDLE if req_valid[owner] is low in any GRANT cycle, including the first.
REQ-025 The block SHALL insert exactly one IDLE cycle between consecutive grants; no two grants SHALL overlap.
REQ-026 Requesters SHALL hold req_valid and req_data until req_ready; the block SHALL never drop or duplicate an accepted word.
REQ-027 Round-robin selection SHALL be starvation-free: a continuously valid requester SHALL be granted within NREQ grants.

Reset
REQ-028 On reset_n low, state SHALL be IDLE, owner=0, beats=0, last_owner=NREQ-1, and beat_count SHALL be all 0.
REQ-029 On reset_n low, wen=0, req_ready=0, data_in=0, grant_id=0 and busy=0 SHALL apply immediately.
REQ-030 Reset asserted mid-burst SHALL abort the grant with no further write.
REQ-031 After reset, requester 0 SHALL have first priority.

Configuration
REQ-032 With FIFO_ARB_STATS_EN defined, beat_count[i] SHALL increment by 1 on each accepted beat of requester i and saturate at 16'hFFFF.
REQ-033 Without FIFO_ARB_STATS_EN, beat_count SHALL be driven constant 0 and no counter flops SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-034 All four valid continuously, full=0, BURST=4: grants follow 0,1,2,3,0 with 4 beats each, and wen drops for exactly 1 cycle between grants.
REQ-035 Only requester 2 valid, delivering 3 words and then dropping valid: 3 writes occur, the block returns to IDLE, and grant_id=0 in IDLE.
REQ-036 full asserted for 5 cycles mid-burst on requester 1: wen=0 and req_ready=0 for those 5 cycles, the grant is held, and the burst completes 4 beats after full deasserts.
REQ-037 reset_n pulled low after beat 2 of a burst: wen=0 immediately, and after release requester 0 is granted first.
REQ-038 With FIFO_ARB_STATS_EN defined and 100 beats from requester 3: beat_count[3]=100 and the other counters are 0. Without the macro: all counters read 0.
REQ-039 Integration with the async FIFO (WIDTH=8, LOG2DEPTH=5), where requester i sends the sequence i*64+n: the read side receives each sequence in order, with no loss and no duplication.
